// File: rtl/rmii_dibit_tx.sv
// RMII transmit serializer: bytes in, LSB-first dibits out, with optional preamble/SFD and enforced IFG.
// Latency: one cycle from byte acceptance to first dibit (plus 32 with preamble). Back-pressure via registered axiir.
module rmii_dibit_tx #(
    parameter int PREAMBLE   = 1,
    parameter int IFG_DIBITS = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    input  logic       axiilast,
    output logic       axiir,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       underrun
);

    localparam int GW = $clog2(IFG_DIBITS + 1);
    localparam logic [GW-1:0] GLAST = GW'(IFG_DIBITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state;
    logic [7:0]    hold;
    logic          last;
    logic [1:0]    cnt;
    logic [4:0]    pcnt;
    logic [GW-1:0] gcnt;
    logic [1:0]    nxt_dibit;

    always_comb begin
        nxt_dibit = hold[1:0];
        case (cnt)
            2'd0:    nxt_dibit = hold[3:2];
            2'd1:    nxt_dibit = hold[5:4];
            2'd2:    nxt_dibit = hold[7:6];
            default: nxt_dibit = hold[1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            hold     <= 8'h00;
            last     <= 1'b0;
            cnt      <= 2'd0;
            pcnt     <= 5'd0;
            gcnt     <= '0;
            axiir    <= 1'b0;
            axiov    <= 1'b0;
            axiod    <= 2'b00;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    axiir <= 1'b1;
                    axiov <= 1'b0;
                    axiod <= 2'b00;
                    busy  <= 1'b0;
                    if (axiiv && axiir) begin
                        hold  <= axiid;
                        last  <= axiilast;
                        axiir <= 1'b0;
                        axiov <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= 2'd0;
                        pcnt  <= 5'd0;
                        if (PREAMBLE != 0) begin
                            state <= S_PRE;
                            axiod <= 2'b01;
                        end else begin
                            state <= S_DATA;
                            axiod <= axiid[1:0];
                        end
                    end
                end
                S_PRE: begin
                    pcnt <= pcnt + 5'd1;
                    if (pcnt == 5'd30) begin
                        axiod <= 2'b11;
                    end else if (pcnt == 5'd31) begin
                        state <= S_DATA;
                        cnt   <= 2'd0;
                        axiod <= hold[1:0];
                    end
                end
                S_DATA: begin
                    cnt   <= cnt + 2'd1;
                    axiod <= nxt_dibit;
                    // Ready is registered, so it is raised one edge before the cnt==3 slot.
                    if (cnt == 2'd2)
                        axiir <= ~last;
                    if (cnt == 2'd3) begin
                        axiir <= 1'b0;
                        if (!last && axiiv && axiir) begin
                            hold  <= axiid;
                            last  <= axiilast;
                            cnt   <= 2'd0;
                            axiod <= axiid[1:0];
                        end else begin
                            underrun <= ~last;
                            axiov    <= 1'b0;
                            axiod    <= 2'b00;
                            // The IDLE cycle that offers ready is itself one of the gap cycles.
                            if (IFG_DIBITS <= 1) begin
                                state <= S_IDLE;
                                axiir <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_GAP;
                                gcnt  <= GW'(1);
                            end
                        end
                    end
                end
                default: begin
                    axiov <= 1'b0;
                    axiod <= 2'b00;
                    if (gcnt >= GLAST) begin
                        state <= S_IDLE;
                        axiir <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_dibit_tx.sv
// Directed bench for rmii_dibit_tx: three instances (no preamble, preamble, short IFG).
module tb_rmii_dibit_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       iv [3];
    logic [7:0] id [3];
    logic       il [3];
    logic       ir [3];
    logic       ov [3];
    logic [1:0] od [3];
    logic       bz [3];
    logic       ur [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rmii_dibit_tx #(.PREAMBLE(0), .IFG_DIBITS(48)) u0 (
        .clk(clk), .rst(rst), .axiiv(iv[0]), .axiid(id[0]), .axiilast(il[0]),
        .axiir(ir[0]), .axiov(ov[0]), .axiod(od[0]), .busy(bz[0]), .underrun(ur[0]));

    rmii_dibit_tx #(.PREAMBLE(1), .IFG_DIBITS(48)) u1 (
        .clk(clk), .rst(rst), .axiiv(iv[1]), .axiid(id[1]), .axiilast(il[1]),
        .axiir(ir[1]), .axiov(ov[1]), .axiod(od[1]), .busy(bz[1]), .underrun(ur[1]));

    rmii_dibit_tx #(.PREAMBLE(0), .IFG_DIBITS(4)) u2 (
        .clk(clk), .rst(rst), .axiiv(iv[2]), .axiid(id[2]), .axiilast(il[2]),
        .axiir(ir[2]), .axiov(ov[2]), .axiod(od[2]), .busy(bz[2]), .underrun(ur[2]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k, input int limit);
        int n = 0;
        while (ir[k] !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (ir[k] !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready u%0d: axiir=%b after %0d cycles, want 1", k, ir[k], n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0;
            id[k] = 8'h00;
            il[k] = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ov[k], od[k], ir[k], bz[k], ur[k]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_values u%0d: got %b want 000000", k,
                         {ov[k], od[k], ir[k], bz[k], ur[k]});
            end
        end
        repeat (2) tick();
        checks++;
        if (ir[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_ready: axiir=%b want 0", ir[0]);
        end
        @(negedge clk) rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ir[k], bz[k], ov[k]} !== 3'b100) begin
                errors++;
                $display("FAIL reset_release u%0d: {ir,busy,ov}=%b want 100", k, {ir[k], bz[k], ov[k]});
            end
        end
    endtask

    task automatic test_single_byte;
        logic [1:0] e [4];
        e = '{2'b11, 2'b10, 2'b10, 2'b10};
        iv[0] = 1'b1; id[0] = 8'hAB; il[0] = 1'b1;
        tick();
        iv[0] = 1'b0; il[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ov[0], od[0], ir[0], bz[0]} !== {1'b1, e[i], 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL single_dibit%0d: {ov,od,ir,busy}=%b want %b", i,
                         {ov[0], od[0], ir[0], bz[0]}, {1'b1, e[i], 1'b0, 1'b1});
            end
            tick();
        end
        for (int i = 0; i < 48; i++) begin
            checks++;
            if ({ov[0], od[0], ir[0]} !== {1'b0, 2'b00, (i == 47)}) begin
                errors++;
                $display("FAIL single_gap%0d: {ov,od,ir}=%b want %b", i,
                         {ov[0], od[0], ir[0]}, {1'b0, 2'b00, (i == 47)});
            end
            if (i < 47) tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] e [12];
        e = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11};
        iv[0] = 1'b1; id[0] = 8'hAA; il[0] = 1'b0;
        tick();
        id[0] = 8'hBB;
        for (int j = 0; j < 12; j++) begin
            checks++;
            if ({ov[0], od[0], ir[0]} !== {1'b1, e[j], (j == 3 || j == 7)}) begin
                errors++;
                $display("FAIL b2b_dibit%0d: {ov,od,ir}=%b want %b", j,
                         {ov[0], od[0], ir[0]}, {1'b1, e[j], (j == 3 || j == 7)});
            end
            tick();
            if (j == 3) begin id[0] = 8'hCC; il[0] = 1'b1; end
            if (j == 7) begin iv[0] = 1'b0; il[0] = 1'b0; end
        end
        checks++;
        if ({ov[0], ur[0]} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: {ov,underrun}=%b want 00", {ov[0], ur[0]});
        end
        wait_ready(0, 60);
    endtask

    task automatic test_preamble;
        logic [1:0] d [4];
        logic [1:0] x;
        d = '{2'b10, 2'b00, 2'b01, 2'b00};
        iv[1] = 1'b1; id[1] = 8'h12; il[1] = 1'b1;
        tick();
        iv[1] = 1'b0; il[1] = 1'b0;
        for (int i = 0; i < 36; i++) begin
            x = (i < 31) ? 2'b01 : (i == 31) ? 2'b11 : d[(i >= 32) ? i - 32 : 0];
            checks++;
            if ({ov[1], od[1]} !== {1'b1, x}) begin
                errors++;
                $display("FAIL pre_dibit%0d: {ov,od}=%b want %b", i, {ov[1], od[1]}, {1'b1, x});
            end
            tick();
        end
        checks++;
        if ({ov[1], od[1], ur[1]} !== 4'b0000) begin
            errors++;
            $display("FAIL pre_end: {ov,od,underrun}=%b want 0000", {ov[1], od[1], ur[1]});
        end
        wait_ready(1, 60);
    endtask

    task automatic test_underrun;
        logic [1:0] e [4];
        e = '{2'b00, 2'b01, 2'b11, 2'b00};
        iv[0] = 1'b1; id[0] = 8'h34; il[0] = 1'b0;
        tick();
        iv[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ov[0], od[0], ur[0]} !== {1'b1, e[i], 1'b0}) begin
                errors++;
                $display("FAIL urun_dibit%0d: {ov,od,underrun}=%b want %b", i,
                         {ov[0], od[0], ur[0]}, {1'b1, e[i], 1'b0});
            end
            tick();
        end
        checks++;
        if ({ur[0], ov[0], od[0], ir[0]} !== 5'b10000) begin
            errors++;
            $display("FAIL urun_pulse: {underrun,ov,od,ir}=%b want 10000", {ur[0], ov[0], od[0], ir[0]});
        end
        for (int i = 2; i <= 48; i++) begin
            tick();
            checks++;
            if ({ur[0], ov[0], ir[0]} !== {2'b00, (i == 48)}) begin
                errors++;
                $display("FAIL urun_gap%0d: {underrun,ov,ir}=%b want %b", i,
                         {ur[0], ov[0], ir[0]}, {2'b00, (i == 48)});
            end
        end
    endtask

    task automatic test_ifg;
        logic [1:0] e [4];
        int gap = 0;
        e = '{2'b10, 2'b10, 2'b01, 2'b01};
        iv[2] = 1'b1; id[2] = 8'h5A; il[2] = 1'b1;
        tick();
        id[2] = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ov[2], od[2]} !== {1'b1, e[i]}) begin
                errors++;
                $display("FAIL ifg_dibit%0d: {ov,od}=%b want %b", i, {ov[2], od[2]}, {1'b1, e[i]});
            end
            tick();
        end
        while (ov[2] !== 1'b1 && gap < 20) begin
            gap++;
            tick();
        end
        iv[2] = 1'b0; il[2] = 1'b0;
        checks++;
        if (gap != 4) begin
            errors++;
            $display("FAIL ifg_gap: idle cycles=%0d want 4", gap);
        end
        checks++;
        if ({ov[2], od[2]} !== 3'b111) begin
            errors++;
            $display("FAIL ifg_frame2: {ov,od}=%b want 111", {ov[2], od[2]});
        end
        wait_ready(2, 40);
    endtask

    task automatic test_midframe_reset;
        logic [1:0] e [4];
        e = '{2'b11, 2'b11, 2'b00, 2'b00};
        iv[0] = 1'b1; id[0] = 8'h11; il[0] = 1'b0;
        tick();
        id[0] = 8'h22;
        repeat (4) tick();
        id[0] = 8'h33; il[0] = 1'b1;
        tick();
        checks++;
        if ({ov[0], od[0], bz[0]} !== 4'b1001) begin
            errors++;
            $display("FAIL mid_before: {ov,od,busy}=%b want 1001", {ov[0], od[0], bz[0]});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ov[0], od[0], ir[0], bz[0], ur[0]} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset: {ov,od,ir,busy,underrun}=%b want 000000",
                     {ov[0], od[0], ir[0], bz[0], ur[0]});
        end
        iv[0] = 1'b0; il[0] = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick();
        checks++;
        if ({ir[0], ur[0], ov[0]} !== 3'b100) begin
            errors++;
            $display("FAIL mid_release: {ir,underrun,ov}=%b want 100", {ir[0], ur[0], ov[0]});
        end
        iv[0] = 1'b1; id[0] = 8'h0F; il[0] = 1'b1;
        tick();
        iv[0] = 1'b0; il[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ov[0], od[0], ur[0]} !== {1'b1, e[i], 1'b0}) begin
                errors++;
                $display("FAIL mid_fresh%0d: {ov,od,underrun}=%b want %b", i,
                         {ov[0], od[0], ur[0]}, {1'b1, e[i], 1'b0});
            end
            tick();
        end
        checks++;
        if ({ov[0], ur[0]} !== 2'b00) begin
            errors++;
            $display("FAIL mid_end: {ov,underrun}=%b want 00", {ov[0], ur[0]});
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_preamble();
        test_underrun();
        test_ifg();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
